mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
- Iterative 32x32 shift-add multiplier; the counterpart of the team's sequential restoring divider.
- Serves the MIPS pipeline's MULT/MULTU path and writes a 64-bit product to HI/LO.
- Uses the same start/done handshake as the divider, so the EX-stage stall logic treats both units identically.
- One multiplier bit per cycle; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- multiplicand  input  WIDTH  operand A, captured when start is accepted
- multiplier  input  WIDTH  operand B, captured when start is accepted
- is_signed  input  1  present only when MUL_SIGNED_EN is defined; captured with the operands
- product_hi  output  WIDTH  upper half of the product (HI)
- product_lo  output  WIDTH  lower half of the product (LO)
- busy  output  1  high from the cycle after acceptance until done rises
- done  output  1  sticky completion flag

Behaviour:
- Reset (asynchronous, reset=0):
  - product_hi = 0, product_lo = 0, busy = 0, done = 0.
  - Internal acc = 0, mq = 0, mcand = 0, count = 0.
  - state = IDLE.
  - Reset asserted mid-operation aborts immediately; no partial result reaches the outputs.
- States: IDLE, EXECUTE, FINISH.
- IDLE:
  - If start=1, on that edge ("edge 0"):
    - mcand <= multiplicand; mq <= multiplier; acc <= 0; count <= WIDTH.
    - done <= 0; product_hi and product_lo <= 0; busy <= 1.
    - state <= EXECUTE.
  - If start=0, all registers hold.
- EXECUTE, one iteration per edge while count > 0:
  - sum (WIDTH+1 bits) = acc + (mq[0] ? mcand : 0).
  - {acc, mq} <= {sum, mq} >> 1, a logical right shift of the combined 2*WIDTH+1 bits.
  - count <= count - 1.
  - The edge on which count reaches 0 moves state to FINISH.
- Iterations occupy edges 1..WIDTH.
- FINISH (edge WIDTH+1):
  - product_hi <= acc; product_lo <= mq; done <= 1; busy <= 0; state <= IDLE.
- Latency: done and product are visible after edge 33 when WIDTH=32.
- done stays at 1 and the product holds until the next accepted start clears both.
- start while busy (EXECUTE or FINISH) is ignored; operands are not re-sampled.
- start=1 in the same cycle that done rises: the request is not accepted (state is FINISH). It is accepted on the following edge if start is still high.
- Zero operands need no special case: they run the full latency and produce 0.
- All arithmetic is unsigned modulo 2^(2*WIDTH). There is no overflow, because the full product fits in 2*WIDTH bits.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined:
  - The is_signed port exists.
  - When is_signed=1 at acceptance, mcand and mq are loaded with the two's-complement magnitudes of the operands, and a neg flag = multiplicand[MSB] ^ multiplier[MSB] is registered.
  - In FINISH, {product_hi, product_lo} <= neg ? -{acc, mq} : {acc, mq}.
  - Magnitude of 0x80000000 is 0x80000000, handled unsigned.
  - Latency is unchanged.
  - is_signed=0 behaves exactly as the unsigned build.
- Undefined:
  - No is_signed port, no neg register.
  - Always unsigned (MULTU semantics); the signed MULT path must be handled elsewhere.

Decomposition:
- Package mul_pkg holds:
  - The state encoding (IDLE=0, EXECUTE=1, FINISH=2; 2-bit).
  - The default WIDTH/CNT_W constants.
  - The 2*WIDTH product width constant.
- No sub-module: the adder and shifter are a single always block plus a small combinational sum.
- The signed magnitude and negate logic stays inline under the macro.

Test Plan:
- Basic unsigned: reset released; multiplicand=7, multiplier=6, start pulse.
  - done=1 exactly 33 edges after the accept edge.
  - product_hi=0x00000000, product_lo=0x0000002A; busy=0 at the same time.
- Max unsigned: 0xFFFFFFFF * 0xFFFFFFFF.
  - product_hi=0xFFFFFFFE, product_lo=0x00000001.
  - done stays 1 for 10 idle cycles with the product held.
- Busy ignore: start 12*12; at edge 5, drive start=1 with 3*3.
  - Result 0x0000000000000090.
  - done rises once at edge 33; the second request is not run.
- Reset mid-op: start 0x1234*0x5678; assert reset at edge 10.
  - All outputs 0 immediately.
  - After release, new 2*3 gives 6 with normal latency.
- Signed (MUL_SIGNED_EN defined, is_signed=1):
  - -3 * 5 gives hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - 0x80000000 * 0x80000000 gives hi=0x40000000, lo=0x00000000.
- Zero/back-to-back: 0 * 0xDEADBEEF gives 0.
  - Keep start high through done; the next operation is accepted on the edge after done rises, and done drops that edge.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the iterative shift-add multiplier.
package mul_pkg;

    localparam int MUL_WIDTH  = 32;
    localparam int MUL_CNT_W  = 6;
    localparam int MUL_PROD_W = 2 * MUL_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXECUTE = 2'd1,
        FINISH  = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, start/done handshake.
// Optional signed operation (MULT) when MUL_SIGNED_EN is defined; default is unsigned only.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
`ifdef MUL_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic             busy,
    output logic             done
);

    localparam int PW = 2 * WIDTH;

    mul_state_t       state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mq_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [CNT_W-1:0] count_reg;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] load_a;
    logic [WIDTH-1:0] load_b;
    logic [PW-1:0]    raw_product;
    logic [PW-1:0]    final_product;

    assign sum         = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, mcand_reg} : '0);
    assign raw_product = {acc_reg, mq_reg};

`ifdef MUL_SIGNED_EN
    logic neg_reg;
    logic load_neg;

    // Magnitude of the most negative value wraps to itself, which is correct read as unsigned.
    assign load_a   = (is_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign load_b   = (is_signed && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    assign load_neg = is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
    assign final_product = neg_reg ? -raw_product : raw_product;
`else
    assign load_a        = multiplicand;
    assign load_b        = multiplier;
    assign final_product = raw_product;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mq_reg     <= '0;
            mcand_reg  <= '0;
            count_reg  <= '0;
            product_hi <= '0;
            product_lo <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef MUL_SIGNED_EN
            neg_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg  <= load_a;
                        mq_reg     <= load_b;
                        acc_reg    <= '0;
                        count_reg  <= CNT_W'(WIDTH);
                        done       <= 1'b0;
                        product_hi <= '0;
                        product_lo <= '0;
                        busy       <= 1'b1;
                        state_reg  <= EXECUTE;
`ifdef MUL_SIGNED_EN
                        neg_reg    <= load_neg;
`endif
                    end
                end
                EXECUTE: begin
                    // {acc, mq} <= {sum, mq} >> 1: low sum bit enters the top of mq.
                    acc_reg   <= sum[WIDTH:1];
                    mq_reg    <= {sum[0], mq_reg[WIDTH-1:1]};
                    count_reg <= count_reg - CNT_W'(1);
                    if (count_reg == CNT_W'(1)) begin
                        state_reg <= FINISH;
                    end
                end
                FINISH: begin
                    product_hi <= final_product[PW-1:WIDTH];
                    product_lo <= final_product[WIDTH-1:0];
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: expected products queued at issue, compared at completion.
// Signed cases run only when MUL_SIGNED_EN is defined.
`timescale 1ns/1ps
module tb_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
`ifdef MUL_SIGNED_EN
    logic        is_signed;
`endif
    logic [31:0] product_hi;
    logic [31:0] product_lo;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    logic [63:0] exp_q[$];

    mul_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
`ifdef MUL_SIGNED_EN
        .is_signed    (is_signed),
`endif
        .product_hi   (product_hi),
        .product_lo   (product_lo),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done, then checks latency relative to the accept edge.
    task automatic wait_done(input string tag, input int acc_edge);
        for (int i = 0; i < 60; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        check({tag, "_latency"}, 64'(edge_cnt - acc_edge), 64'd33);
    endtask

    task automatic check_result(input string tag);
        logic [63:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            exp = exp_q.pop_front();
            $display("op %s: hi=%h lo=%h expected=%h", tag, product_hi, product_lo, exp);
            check({tag, "_hi"}, {32'd0, product_hi}, {32'd0, exp[63:32]});
            check({tag, "_lo"}, {32'd0, product_lo}, {32'd0, exp[31:0]});
            check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int acc_edge;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        acc_edge = edge_cnt;
        check({tag, "_busy_hi"}, {62'd0, busy, done}, 64'd2);
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, acc_edge);
        check_result(tag);
    endtask

    initial begin
        int acc_edge;
        reset        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
`ifdef MUL_SIGNED_EN
        is_signed    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {product_hi, product_lo}, 64'd0);
        check("reset_flags", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("basic", 32'd7, 32'd6, 64'h0000_0000_0000_002A);

        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("max_hold", {product_hi, product_lo}, 64'hFFFF_FFFE_0000_0001);
            check("max_done_hold", {63'd0, done}, 64'd1);
        end

        // Second request during EXECUTE must be ignored.
        @(negedge clk);
        multiplicand = 32'd12;
        multiplier   = 32'd12;
        start        = 1'b1;
        exp_q.push_back(64'h90);
        @(posedge clk);
        #1;
        acc_edge = edge_cnt;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        multiplicand = 32'd3;
        multiplier   = 32'd3;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ignore", acc_edge);
        check_result("busy_ignore");
        repeat (40) @(posedge clk);
        #1;
        check("busy_ignore_no_rerun", {62'd0, busy, done}, 64'd1);
        check("busy_ignore_held", {product_hi, product_lo}, 64'h90);

        // Reset in the middle of an operation.
        @(negedge clk);
        multiplicand = 32'h1234;
        multiplier   = 32'h5678;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        check("midop_reset_out", {product_hi, product_lo}, 64'd0);
        check("midop_reset_flags", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("after_reset", 32'd2, 32'd3, 64'd6);

`ifdef MUL_SIGNED_EN
        is_signed = 1'b1;
        run_op("signed_neg", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("signed_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        is_signed = 1'b0;
        run_op("unsigned_in_signed", 32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1);
`endif

        // Zero operand, start held high straight through to a back-to-back op.
        @(negedge clk);
        multiplicand = 32'd0;
        multiplier   = 32'hDEAD_BEEF;
        start        = 1'b1;
        exp_q.push_back(64'd0);
        @(posedge clk);
        #1;
        acc_edge = edge_cnt;
        @(negedge clk);
        multiplicand = 32'd5;
        multiplier   = 32'd9;
        wait_done("zero", acc_edge);
        check_result("zero");
        exp_q.push_back(64'd45);
        @(posedge clk);
        #1;
        acc_edge = edge_cnt;
        check("b2b_accept", {62'd0, busy, done}, 64'd2);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b", acc_edge);
        check_result("b2b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
